// File: rtl/dut_pkt_gate.sv
// dut_pkt_gate: byte FIFO whose head is released only inside a length-gated
// packet window, with a small register port for enable/flush and counters.
//
// Handshake: each method port has an en strobe and a rdy indicator. A
// transfer happens at the rising clock edge where en=1 and rdy=1; an en seen
// while rdy=0 has no effect. All rdy outputs are held low while RST_N=0.
module dut_pkt_gate #(
  parameter int DEPTH = 8
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [7:0]  din_value,
  input  logic        din_en,
  output logic        din_rdy,
  input  logic        dout_en,
  output logic [7:0]  dout_value,
  output logic        dout_rdy,
  input  logic [7:0]  len_value,
  input  logic        len_en,
  output logic        len_rdy,
  input  logic [7:0]  cfg_address,
  input  logic [31:0] cfg_data_in,
  input  logic        cfg_op,
  input  logic        cfg_en,
  output logic [31:0] cfg_data_out,
  output logic        cfg_rdy
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [7:0] ADDR_CTRL   = 8'h00;
  localparam logic [7:0] ADDR_STATUS = 8'h04;
  localparam logic [7:0] ADDR_PKT    = 8'h08;
  localparam logic [7:0] ADDR_BYTE   = 8'h0C;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic [7:0]    remaining;
  logic          enable;
  logic [31:0]   pkt_count;
  logic [31:0]   byte_count;

  logic        full;
  logic        empty;
  logic        cfg_wr;
  logic        cfg_rd;
  logic        flush;
  logic        push;
  logic        pop;
  logic        len_acc;
  logic        pkt_done;
  logic        clr_pkt;
  logic        clr_byte;
  logic [31:0] status;
  logic [31:0] rd_data;
  logic        unused_cfg_bits;

  // count reaches DEPTH only when its top bit is set (DEPTH is a power of 2)
  assign full  = count[AW];
  assign empty = (count == '0);

  assign din_rdy  = RST_N & ~full;
  assign len_rdy  = RST_N & (remaining == 8'd0);
  assign dout_rdy = RST_N & enable & (remaining != 8'd0) & ~empty;
  assign cfg_rdy  = RST_N;

  assign dout_value = empty ? 8'h00 : mem[rd_ptr];

  assign cfg_wr = cfg_rdy & cfg_en & cfg_op;
  assign cfg_rd = cfg_rdy & cfg_en & ~cfg_op;

  // Flush overrides any same-cycle push, pop or length command.
  assign flush    = cfg_wr & (cfg_address == ADDR_CTRL) & cfg_data_in[1];
  assign push     = din_en & din_rdy & ~flush;
  assign pop      = dout_en & dout_rdy & ~flush;
  assign len_acc  = len_en & len_rdy & ~flush;
  assign pkt_done = pop & (remaining == 8'd1);
  assign clr_pkt  = cfg_wr & (cfg_address == ADDR_PKT);
  assign clr_byte = cfg_wr & (cfg_address == ADDR_BYTE);

  assign status = {8'h00, remaining, 5'b00000, empty, full,
                   (remaining != 8'd0), 8'(count)};

  assign unused_cfg_bits = ^cfg_data_in[31:2];

  // Register read mux; unmapped addresses return zero.
  always_comb begin
    rd_data = 32'h0;
    case (cfg_address)
      ADDR_CTRL:   rd_data = {31'h0, enable};
      ADDR_STATUS: rd_data = status;
      ADDR_PKT:    rd_data = pkt_count;
      ADDR_BYTE:   rd_data = byte_count;
      default:     rd_data = 32'h0;
    endcase
  end

  assign cfg_data_out = cfg_rd ? rd_data : 32'h0;

  // Storage array: written on every accepted push, never reset.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= din_value;
  end

  // FIFO pointers/occupancy, packet window, enable bit and counters.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      remaining  <= 8'd0;
      enable     <= 1'b1;
      pkt_count  <= 32'h0;
      byte_count <= 32'h0;
    end else begin
      if (flush) begin
        rd_ptr    <= '0;
        wr_ptr    <= '0;
        count     <= '0;
        remaining <= 8'd0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        if (push && !pop)      count <= count + 1'b1;
        else if (pop && !push) count <= count - 1'b1;
        if (len_acc)  remaining <= len_value;
        else if (pop) remaining <= remaining - 8'd1;
      end

      if (cfg_wr && (cfg_address == ADDR_CTRL)) enable <= cfg_data_in[0];

      // A clear written in the same cycle as an increment leaves zero.
      if (clr_pkt)       pkt_count <= 32'h0;
      else if (pkt_done) pkt_count <= pkt_count + 32'd1;

      if (clr_byte) byte_count <= 32'h0;
      else if (pop) byte_count <= byte_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_dut_pkt_gate.sv
// Testbench for dut_pkt_gate: directed stimulus, expected dout bytes queued
// at push time and checked by an independent monitor on each accepted pop.
module tb_dut_pkt_gate;

  logic        CLK;
  logic        RST_N;
  logic [7:0]  din_value;
  logic        din_en;
  logic        din_rdy;
  logic        dout_en;
  logic [7:0]  dout_value;
  logic        dout_rdy;
  logic [7:0]  len_value;
  logic        len_en;
  logic        len_rdy;
  logic [7:0]  cfg_address;
  logic [31:0] cfg_data_in;
  logic        cfg_op;
  logic        cfg_en;
  logic [31:0] cfg_data_out;
  logic        cfg_rdy;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  dut_pkt_gate #(.DEPTH(8)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .din_value(din_value), .din_en(din_en), .din_rdy(din_rdy),
    .dout_en(dout_en), .dout_value(dout_value), .dout_rdy(dout_rdy),
    .len_value(len_value), .len_en(len_en), .len_rdy(len_rdy),
    .cfg_address(cfg_address), .cfg_data_in(cfg_data_in), .cfg_op(cfg_op),
    .cfg_en(cfg_en), .cfg_data_out(cfg_data_out), .cfg_rdy(cfg_rdy)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard monitor ----------------
  // A pop is committed at the next rising edge when en and rdy are both high
  // at the falling edge (inputs only change just after rising edges).
  always @(negedge CLK) begin
    if (RST_N && dout_en && dout_rdy) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL dout_unexpected: got %02h, expected no byte", dout_value);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (dout_value !== e) begin
          errors++;
          $display("FAIL dout_byte: got %02h, expected %02h", dout_value, e);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    din_value = b;
    din_en = 1'b1;
    exp_q.push_back(b);
    cycle();
    din_en = 1'b0;
  endtask

  task automatic set_len(input logic [7:0] n);
    len_value = n;
    len_en = 1'b1;
    cycle();
    len_en = 1'b0;
  endtask

  task automatic pop(input int n);
    int done = 0;
    int waited = 0;
    dout_en = 1'b1;
    while (done < n && waited < 50) begin
      if (dout_rdy) done++;
      cycle();
      waited++;
    end
    dout_en = 1'b0;
    if (done < n) begin
      checks++;
      errors++;
      $display("FAIL pop_timeout: got %0d pops, expected %0d", done, n);
    end
  endtask

  task automatic cfg_write(input logic [7:0] a, input logic [31:0] d);
    cfg_address = a;
    cfg_data_in = d;
    cfg_op = 1'b1;
    cfg_en = 1'b1;
    cycle();
    cfg_en = 1'b0;
    cfg_op = 1'b0;
  endtask

  task automatic cfg_read(input string name, input logic [7:0] a, input logic [31:0] exp);
    cfg_address = a;
    cfg_op = 1'b0;
    cfg_en = 1'b1;
    #1;
    check(name, cfg_data_out, exp);
    cfg_en = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    RST_N = 1'b0;
    din_value = 8'h00; din_en = 1'b0; dout_en = 1'b0;
    len_value = 8'h00; len_en = 1'b0;
    cfg_address = 8'h00; cfg_data_in = 32'h0; cfg_op = 1'b0; cfg_en = 1'b0;

    // Reset behaviour
    repeat (3) cycle();
    check("rst_din_rdy", din_rdy, 0);
    check("rst_len_rdy", len_rdy, 0);
    check("rst_dout_rdy", dout_rdy, 0);
    check("rst_cfg_rdy", cfg_rdy, 0);
    check("rst_dout_value", dout_value, 0);
    cfg_read("rst_cfg_data_out", 8'h00, 32'h0);
    RST_N = 1'b1;
    #1;
    check("rel_din_rdy", din_rdy, 1);
    check("rel_len_rdy", len_rdy, 1);
    check("rel_dout_rdy", dout_rdy, 0);
    check("rel_cfg_rdy", cfg_rdy, 1);
    cycle();
    cfg_read("rel_ctrl", 8'h00, 32'h1);
    cfg_read("rel_status", 8'h04, 32'h400);

    // Basic packet
    push(8'h11); push(8'h22); push(8'h33);
    set_len(8'd2);
    check("basic_dout_rdy", dout_rdy, 1);
    check("basic_len_rdy_busy", len_rdy, 0);
    pop(2);
    check("basic_dout_rdy_drop", dout_rdy, 0);
    check("basic_len_rdy", len_rdy, 1);
    cfg_read("basic_pkt", 8'h08, 32'd1);
    cfg_read("basic_byte", 8'h0C, 32'd2);
    cfg_read("basic_status", 8'h04, 32'h001);

    // Drain the leftover byte, then length before data
    set_len(8'd1);
    pop(1);
    set_len(8'd3);
    check("lfirst_dout_rdy", dout_rdy, 0);
    check("lfirst_len_rdy", len_rdy, 0);
    cfg_read("lfirst_status", 8'h04, 32'h30500);
    push(8'hA0);
    check("lfirst_dout_rdy_after_push", dout_rdy, 1);
    cfg_read("lfirst_status_rem", 8'h04, 32'h30101);
    push(8'hB1); push(8'hC2);
    pop(3);
    check("lfirst_len_rdy_done", len_rdy, 1);

    // Len 0 is a no-op
    set_len(8'd0);
    check("len0_len_rdy", len_rdy, 1);
    cfg_read("len0_status", 8'h04, 32'h400);

    // Full FIFO
    for (int i = 0; i < 8; i++) push(8'h40 + 8'(i));
    check("full_din_rdy", din_rdy, 0);
    cfg_read("full_status", 8'h04, 32'h208);
    din_value = 8'hEE; din_en = 1'b1;
    cycle();
    din_en = 1'b0;
    cfg_read("full_status_after_9th", 8'h04, 32'h208);
    set_len(8'd8);
    pop(8);
    cfg_read("full_status_empty", 8'h04, 32'h400);
    cfg_read("full_pkt", 8'h08, 32'd4);
    cfg_read("full_byte", 8'h0C, 32'd14);

    // Control: enable stall, resume, flush mid-packet
    push(8'h55); push(8'h66); push(8'h77);
    cfg_write(8'h00, 32'h0);
    set_len(8'd2);
    check("ctrl_stall_dout_rdy", dout_rdy, 0);
    cfg_read("ctrl_read0", 8'h00, 32'h0);
    cfg_write(8'h00, 32'h1);
    check("ctrl_resume_dout_rdy", dout_rdy, 1);
    pop(1);
    cfg_write(8'h00, 32'h3);
    exp_q.delete();
    check("flush_len_rdy", len_rdy, 1);
    check("flush_dout_rdy", dout_rdy, 0);
    cfg_read("flush_status", 8'h04, 32'h400);
    cfg_read("flush_ctrl", 8'h00, 32'h1);
    cfg_read("flush_pkt", 8'h08, 32'd4);
    cfg_read("flush_byte", 8'h0C, 32'd15);

    // Simultaneous push and pop at count=4
    for (int i = 0; i < 4; i++) push(8'h81 + 8'(i));
    set_len(8'd5);
    din_value = 8'h85; din_en = 1'b1; dout_en = 1'b1;
    exp_q.push_back(8'h85);
    cycle();
    din_en = 1'b0; dout_en = 1'b0;
    cfg_read("simul_status", 8'h04, 32'h40104);
    pop(4);
    cfg_read("simul_status_done", 8'h04, 32'h400);
    cfg_read("simul_pkt", 8'h08, 32'd5);

    // Unmapped address
    cfg_write(8'h10, 32'hFFFF_FFFF);
    cfg_read("unmapped_read", 8'h10, 32'h0);
    cfg_read("unmapped_ctrl", 8'h00, 32'h1);

    // Reset mid-packet
    push(8'h91); push(8'h92);
    set_len(8'd5);
    pop(1);
    RST_N = 1'b0;
    exp_q.delete();
    #1;
    check("midrst_din_rdy", din_rdy, 0);
    check("midrst_dout_value", dout_value, 0);
    cycle();
    RST_N = 1'b1;
    #1;
    check("midrst_len_rdy", len_rdy, 1);
    cfg_read("midrst_status", 8'h04, 32'h400);
    cfg_read("midrst_pkt", 8'h08, 32'd0);
    cfg_read("midrst_byte", 8'h0C, 32'd0);

    // Counter clear, including clear concurrent with an increment
    cycle();
    push(8'hA1);
    set_len(8'd1);
    pop(1);
    cfg_read("clr_pkt_before", 8'h08, 32'd1);
    cfg_write(8'h08, 32'h1234);
    cfg_read("clr_pkt_after", 8'h08, 32'd0);
    push(8'hB1);
    set_len(8'd1);
    cfg_address = 8'h08; cfg_data_in = 32'h0; cfg_op = 1'b1; cfg_en = 1'b1;
    dout_en = 1'b1;
    cycle();
    cfg_en = 1'b0; cfg_op = 1'b0; dout_en = 1'b0;
    cfg_read("clr_race_pkt", 8'h08, 32'd0);
    cfg_read("clr_race_byte", 8'h0C, 32'd2);
    cfg_write(8'h0C, 32'h0);
    cfg_read("clr_byte", 8'h0C, 32'd0);

    check("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
